noc_merge2_rr: RTL and testbench
================================

Name: noc_merge2_rr

Overview:
- Clocked downstream merge stage for the routing tree.
- Consumes the two output streams of a decoder leaf, or the matching outputs of two sibling leaves, each carrying 9-bit flits (address in [8:5], payload in [4:0]).
- Round-robin arbitrates the two streams into one output channel through a small FIFO.
- Tags every flit with its source-input index, mirroring the decoder's select token, so the next router level can track ordering.

Parameters:
- W, 9, flit width in bits; the address field is always the top 4 bits [W-1:W-4].
- DEPTH, 2, output FIFO entries; legal values 2..8, power of two not required.

Ports:
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- in0_data  in  W  flit from input 0.
- in0_valid  in  1  input 0 holds a flit.
- in0_ready  out  1  input 0 flit accepted this cycle when high with in0_valid.
- in1_data  in  W  flit from input 1.
- in1_valid  in  1  input 1 holds a flit.
- in1_ready  out  1  input 1 accept strobe.
- out_data  out  W  flit at FIFO head.
- out_src  out  1  source index of head flit (0 = in0, 1 = in1).
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer takes head flit when high with out_valid.

Behaviour:
- Handshake: a transfer occurs on a rising edge where valid and ready are both high.
- Input senders must hold data/valid stable until accepted; the block must not depend on valid deasserting.
- space = (count < DEPTH).
  - Computed from registered count only; a same-cycle pop does not create space (no full-FIFO pass-through).
- Arbitration: combinational grant from in0_valid, in1_valid and the registered last_grant bit.
  - Only one valid: grant it.
  - Both valid: grant the input != last_grant.
  - Neither valid: no grant.
- in0_ready = space & grant==0 & in0_valid; in1_ready likewise. At most one ready is high per cycle.
  - Ready depends combinationally on valid; this is permitted and documented.
- On an accepted flit: write {src, data} at the write pointer, advance the write pointer modulo DEPTH, and set last_grant = src.
  - last_grant does not change on cycles with no accept.
- Pop: when out_valid & out_ready, advance the read pointer modulo DEPTH.
- count: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
  - Count width is clog2(DEPTH+1).
- Pointer wrap: pointers wrap explicitly at DEPTH-1 back to 0, not by bit overflow, so non-power-of-two DEPTH is correct.
- Outputs: out_valid = (count != 0); out_data/out_src are registered storage at the read pointer.
  - Latency: a flit accepted at edge N is visible at out with out_valid high after edge N, i.e. one cycle.
- Full: both readys are low, and inputs stall without loss.
- Empty: out_valid = 0, and out_data/out_src hold their last value (don't-care).
- Ordering:
  - FIFO order equals grant order.
  - Flits from one input are never reordered.
  - Payload and address bits pass unmodified.
- Reset:
  - Clears count, both pointers, and out_valid to 0.
  - Sets last_grant = 1, so in0 wins the first contention.
  - Storage is not cleared.
  - Reset mid-operation drops all buffered flits; in0_ready/in1_ready read 0 while reset is high.

Optional Feature:
- Macro: NOC_MERGE_STATS_EN.
- When defined, add two output ports:
  - stat_cnt0, 16 bits: accepted flits from in0.
  - stat_cnt1, 16 bits: accepted flits from in1.
- Both counters saturate at 16'hFFFF with no wrap, and clear to 0 on reset.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then in0 sends 9'h1C5 with out_ready=1 → in0_ready high in the same cycle; next cycle out_valid=1, out_data=9'h1C5, out_src=0.
- Both inputs valid continuously (in0=9'h0A1, in1=9'h1F2), out_ready=1, 6 cycles → output alternates in0, in1, in0, ... starting with in0, 3 flits each.
- out_ready=0, in1 streams 9'h101, 9'h102, 9'h103 → first two accepted, in1_ready drops with count=DEPTH=2; raise out_ready → 101, 102, 103 emitted in order with out_src=1, no loss.
- FIFO holding 1 entry, with a push and a pop in the same cycle → count stays 1 and the data order is preserved; run 10 such flits to exercise pointer wrap, including DEPTH=3.
- Assert reset while 2 flits are buffered and both inputs are valid → out_valid=0 and both readys 0 immediately; after release, in0 wins the first contention.
- With NOC_MERGE_STATS_EN, send 5 flits on in0 and 3 on in1 → stat_cnt0=5, stat_cnt1=3; force 65536 accepts on in0 → stat_cnt0 holds 16'hFFFF.

Source files
------------

// File: rtl/noc_merge2_rr_if.sv
// noc_merge2_rr_if: two flit input channels and one tagged output channel of the merge stage.
// Latency: none, wires only.
// Backpressure: valid/ready on every channel; slave = merge stage side, master = neighbour side.
interface noc_merge2_rr_if #(
  parameter int W = 9
);
  logic [W-1:0] in0_data;
  logic         in0_valid;
  logic         in0_ready;
  logic [W-1:0] in1_data;
  logic         in1_valid;
  logic         in1_ready;
  logic [W-1:0] out_data;
  logic         out_src;
  logic         out_valid;
  logic         out_ready;

  modport slave (
    input  in0_data, in0_valid,
    output in0_ready,
    input  in1_data, in1_valid,
    output in1_ready,
    output out_data, out_src, out_valid,
    input  out_ready
  );

  modport master (
    output in0_data, in0_valid,
    input  in0_ready,
    output in1_data, in1_valid,
    input  in1_ready,
    input  out_data, out_src, out_valid,
    output out_ready
  );
endinterface

// File: rtl/noc_merge2_rr.sv
// noc_merge2_rr: round-robin merge of two flit streams into one source-tagged output FIFO.
// Latency: a flit accepted at edge N is at the output head after edge N (one cycle).
// Backpressure: ready only with a free slot by registered count; a same-cycle pop frees nothing.
// Optional feature macro NOC_MERGE_STATS_EN adds saturating per-input accept counters.
module noc_merge2_rr #(
  parameter int W     = 9,
  parameter int DEPTH = 2
) (
  input  logic           clk,
  input  logic           reset,
  noc_merge2_rr_if.slave bus
`ifdef NOC_MERGE_STATS_EN
  ,
  output logic [15:0]    stat_cnt0,
  output logic [15:0]    stat_cnt1
`endif
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          last_grant_q, last_grant_d;
  logic [W:0]    mem_q [DEPTH];

  logic          space;
  logic          grant_vld;
  logic          grant_src;
  logic          push;
  logic          pop;
  logic [W-1:0]  push_dat;

  // Pointers wrap at DEPTH-1 explicitly so non-power-of-two depths stay correct.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Space looks only at the registered count: no pass-through when full.
  assign space = (count_q < CW'(DEPTH));

  // Round-robin grant: a lone requester wins, on contention the input not served last wins.
  always_comb begin
    grant_vld = bus.in0_valid | bus.in1_valid;
    grant_src = 1'b0;
    if (bus.in0_valid && bus.in1_valid) begin
      grant_src = ~last_grant_q;
    end else if (bus.in1_valid) begin
      grant_src = 1'b1;
    end
  end

  // Ready depends combinationally on valid; reset forces both low.
  assign bus.in0_ready = ~reset & space & grant_vld & ~grant_src & bus.in0_valid;
  assign bus.in1_ready = ~reset & space & grant_vld &  grant_src & bus.in1_valid;

  assign push     = bus.in0_ready | bus.in1_ready;
  assign push_dat = grant_src ? bus.in1_data : bus.in0_data;
  assign pop      = bus.out_valid & bus.out_ready;

  // Head of the FIFO is presented straight from storage at the read pointer.
  assign bus.out_valid = (count_q != '0);
  assign bus.out_src   = mem_q[rd_ptr_q][W];
  assign bus.out_data  = mem_q[rd_ptr_q][W-1:0];

  // Next-state for pointers, occupancy and the round-robin history bit.
  always_comb begin
    wr_ptr_d     = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d     = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    last_grant_d = push ? grant_src : last_grant_q;
    count_d      = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  // Control state; last_grant resets to 1 so in0 wins the first contention.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      last_grant_q <= 1'b1;
    end else begin
      count_q      <= count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Flit storage is never cleared; entries are tagged with the granted source index.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {grant_src, push_dat};
    end
  end

`ifdef NOC_MERGE_STATS_EN
  logic [15:0] stat_cnt0_q;
  logic [15:0] stat_cnt1_q;

  // Per-input accept counters, saturating at all ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_cnt0_q <= '0;
      stat_cnt1_q <= '0;
    end else begin
      if (bus.in0_ready && stat_cnt0_q != 16'hFFFF) begin
        stat_cnt0_q <= stat_cnt0_q + 16'd1;
      end
      if (bus.in1_ready && stat_cnt1_q != 16'hFFFF) begin
        stat_cnt1_q <= stat_cnt1_q + 16'd1;
      end
    end
  end

  assign stat_cnt0 = stat_cnt0_q;
  assign stat_cnt1 = stat_cnt1_q;
`endif

endmodule

// File: tb/tb_noc_merge2_rr.sv
// tb_noc_merge2_rr: directed stimulus on a DEPTH=2 and a DEPTH=3 merge stage with a queue model.
// Latency: model predicts readys and FIFO head every cycle; literal checks pin key points.
// Backpressure: senders hold data/valid until a sampled ready, bounded by a cycle budget.
module tb_noc_merge2_rr;

  logic clk;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  noc_merge2_rr_if #(.W(9)) b2 ();
  noc_merge2_rr_if #(.W(9)) b3 ();

`ifdef NOC_MERGE_STATS_EN
  logic [15:0] s2c0, s2c1, s3c0, s3c1;
`endif

  noc_merge2_rr #(.W(9), .DEPTH(2)) u_d2 (
    .clk   (clk),
    .reset (reset),
    .bus   (b2.slave)
`ifdef NOC_MERGE_STATS_EN
    ,
    .stat_cnt0 (s2c0),
    .stat_cnt1 (s2c1)
`endif
  );

  noc_merge2_rr #(.W(9), .DEPTH(3)) u_d3 (
    .clk   (clk),
    .reset (reset),
    .bus   (b3.slave)
`ifdef NOC_MERGE_STATS_EN
    ,
    .stat_cnt0 (s3c0),
    .stat_cnt1 (s3c1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Flattened views of both DUTs so the model can loop over them.
  logic       v0 [2], v1 [2], r0 [2], r1 [2], ov [2], os [2], ordy [2];
  logic [8:0] d0 [2], d1 [2], od [2];
  assign v0[0] = b2.in0_valid;  assign v0[1] = b3.in0_valid;
  assign v1[0] = b2.in1_valid;  assign v1[1] = b3.in1_valid;
  assign r0[0] = b2.in0_ready;  assign r0[1] = b3.in0_ready;
  assign r1[0] = b2.in1_ready;  assign r1[1] = b3.in1_ready;
  assign d0[0] = b2.in0_data;   assign d0[1] = b3.in0_data;
  assign d1[0] = b2.in1_data;   assign d1[1] = b3.in1_data;
  assign ov[0] = b2.out_valid;  assign ov[1] = b3.out_valid;
  assign os[0] = b2.out_src;    assign os[1] = b3.out_src;
  assign od[0] = b2.out_data;   assign od[1] = b3.out_data;
  assign ordy[0] = b2.out_ready; assign ordy[1] = b3.out_ready;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: an ordered list of {src,data} per DUT plus who was served last.
  int         mdep [2] = '{2, 3};
  logic [9:0] mq   [2][16];
  int         msz  [2];
  logic       mlg  [2];
  logic [9:0] olog [2][64];
  int         olen [2];
  logic       m_sp, m_e0, m_e1, m_ov;

  initial begin
    msz[0] = 0; msz[1] = 0; mlg[0] = 1'b1; mlg[1] = 1'b1;
    olen[0] = 0; olen[1] = 0;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (reset) begin
          msz[d] = 0;
          mlg[d] = 1'b1;
        end
        m_sp = (msz[d] < mdep[d]);
        m_e0 = !reset && m_sp && v0[d] && (!v1[d] || mlg[d]);
        m_e1 = !reset && m_sp && v1[d] && (!v0[d] || !mlg[d]);
        m_ov = (msz[d] != 0);
        chk($sformatf("dut%0d_in0_ready", d), 32'(r0[d]), 32'(m_e0));
        chk($sformatf("dut%0d_in1_ready", d), 32'(r1[d]), 32'(m_e1));
        chk($sformatf("dut%0d_out_valid", d), 32'(ov[d]), 32'(m_ov));
        if (m_ov) begin
          chk($sformatf("dut%0d_out_data", d), 32'(od[d]), 32'(mq[d][0][8:0]));
          chk($sformatf("dut%0d_out_src", d), 32'(os[d]), 32'(mq[d][0][9]));
        end
        if (!reset) begin
          if (m_ov && ordy[d]) begin
            if (olen[d] < 64) olog[d][olen[d]] = mq[d][0];
            olen[d]++;
            for (int i = 0; i < 15; i++) mq[d][i] = mq[d][i+1];
            msz[d]--;
          end
          if (m_e0) begin
            mq[d][msz[d]] = {1'b0, d0[d]};
            msz[d]++;
            mlg[d] = 1'b0;
          end
          if (m_e1) begin
            mq[d][msz[d]] = {1'b1, d1[d]};
            msz[d]++;
            mlg[d] = 1'b1;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic clr_log();
    olen[0] = 0;
    olen[1] = 0;
  endtask

  task automatic set_in(input int d, input int p, input logic [8:0] dat, input logic v);
    if (d == 0) begin
      if (p == 0) begin b2.in0_data = dat; b2.in0_valid = v; end
      else        begin b2.in1_data = dat; b2.in1_valid = v; end
    end else begin
      if (p == 0) begin b3.in0_data = dat; b3.in0_valid = v; end
      else        begin b3.in1_data = dat; b3.in1_valid = v; end
    end
  endtask

  // Offer one flit and hold it until a ready is sampled, within a cycle budget.
  task automatic send(input int d, input int p, input logic [8:0] dat);
    bit acc;
    acc = 1'b0;
    set_in(d, p, dat, 1'b1);
    for (int k = 0; k < 64 && !acc; k++) begin
      @(negedge clk);
      acc = (p == 0) ? r0[d] : r1[d];
      @(posedge clk);
      #1;
    end
    set_in(d, p, dat, 1'b0);
    if (!acc) chk($sformatf("send_timeout_d%0d_p%0d", d, p), 32'd0, 32'd1);
  endtask

  function automatic logic [8:0] wdat(input int i);
    return 9'((i * 37 + 5) & 511);
  endfunction

  initial begin
    reset = 1'b0;
    b2.in0_data = '0; b2.in0_valid = 1'b0; b2.in1_data = '0; b2.in1_valid = 1'b0; b2.out_ready = 1'b0;
    b3.in0_data = '0; b3.in0_valid = 1'b0; b3.in1_data = '0; b3.in1_valid = 1'b0; b3.out_ready = 1'b0;
    #2 reset = 1'b1;
    b2.in0_valid = 1'b1;
    b2.in1_valid = 1'b1;

    // Reset state: nothing buffered, inputs refused while reset is high.
    @(negedge clk);
    chk("rst_out_valid", 32'(b2.out_valid), 32'd0);
    chk("rst_in0_ready", 32'(b2.in0_ready), 32'd0);
    chk("rst_in1_ready", 32'(b2.in1_ready), 32'd0);
    tick();
    b2.in0_valid = 1'b0;
    b2.in1_valid = 1'b0;
    tick();
    reset = 1'b0;

    // Single flit, one-cycle latency.
    b2.out_ready = 1'b1;
    b3.out_ready = 1'b1;
    set_in(0, 0, 9'h1C5, 1'b1);
    @(negedge clk);
    chk("t1_in0_ready", 32'(b2.in0_ready), 32'd1);
    tick();
    set_in(0, 0, 9'h1C5, 1'b0);
    @(negedge clk);
    chk("t1_out_valid", 32'(b2.out_valid), 32'd1);
    chk("t1_out_data", 32'(b2.out_data), 32'h1C5);
    chk("t1_out_src", 32'(b2.out_src), 32'd0);
    tick();
    tick();

    // Contention: alternate starting with in0.
    pulse_reset();
    clr_log();
    set_in(0, 0, 9'h0A1, 1'b1);
    set_in(0, 1, 9'h1F2, 1'b1);
    repeat (6) tick();
    set_in(0, 0, 9'h0A1, 1'b0);
    set_in(0, 1, 9'h1F2, 1'b0);
    repeat (3) tick();
    chk("t2_count", 32'(olen[0]), 32'd6);
    for (int i = 0; i < 6; i++)
      chk($sformatf("t2_flit%0d", i), 32'(olog[0][i]), (i % 2 == 0) ? 32'h0A1 : 32'h3F2);

    // Full FIFO stalls in1 without loss.
    clr_log();
    b2.out_ready = 1'b0;
    send(0, 1, 9'h101);
    send(0, 1, 9'h102);
    fork
      send(0, 1, 9'h103);
      begin
        repeat (3) begin
          @(negedge clk);
          chk("t3_full_in1_ready", 32'(b2.in1_ready), 32'd0);
          chk("t3_head", 32'(b2.out_data), 32'h101);
        end
        @(posedge clk);
        #1;
        b2.out_ready = 1'b1;
      end
    join
    repeat (4) tick();
    chk("t3_count", 32'(olen[0]), 32'd3);
    chk("t3_flit0", 32'(olog[0][0]), 32'h301);
    chk("t3_flit1", 32'(olog[0][1]), 32'h302);
    chk("t3_flit2", 32'(olog[0][2]), 32'h303);

    // One entry held, push and pop every cycle, pointers wrap (DEPTH 2 and 3).
    clr_log();
    b2.out_ready = 1'b0;
    b3.out_ready = 1'b0;
    fork
      send(0, 0, 9'h0AA);
      send(1, 0, 9'h0AA);
    join
    b2.out_ready = 1'b1;
    b3.out_ready = 1'b1;
    fork
      begin for (int i = 0; i < 10; i++) send(0, 0, wdat(i)); end
      begin for (int j = 0; j < 10; j++) send(1, 0, wdat(j)); end
    join
    @(negedge clk);
    chk("t4_d2_last", 32'(b2.out_data), 32'(wdat(9)));
    chk("t4_d3_last", 32'(b3.out_data), 32'(wdat(9)));
    tick();
    repeat (3) tick();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("t4_d%0d_count", d), 32'(olen[d]), 32'd11);
      chk($sformatf("t4_d%0d_first", d), 32'(olog[d][0]), 32'h0AA);
      for (int i = 0; i < 10; i++)
        chk($sformatf("t4_d%0d_flit%0d", d, i), 32'(olog[d][i+1]), 32'(wdat(i)));
    end

    // Reset while full and both inputs pending.
    b2.out_ready = 1'b0;
    send(0, 0, 9'h011);
    send(0, 1, 9'h122);
    set_in(0, 0, 9'h033, 1'b1);
    set_in(0, 1, 9'h144, 1'b1);
    @(negedge clk);
    chk("t5_full_in0_ready", 32'(b2.in0_ready), 32'd0);
    chk("t5_full_in1_ready", 32'(b2.in1_ready), 32'd0);
    tick();
    reset = 1'b1;
    #2;
    chk("t5_rst_out_valid", 32'(b2.out_valid), 32'd0);
    chk("t5_rst_in0_ready", 32'(b2.in0_ready), 32'd0);
    chk("t5_rst_in1_ready", 32'(b2.in1_ready), 32'd0);
    clr_log();
    @(posedge clk);
    #1;
    reset = 1'b0;
    b2.out_ready = 1'b1;
    fork
      send(0, 0, 9'h033);
      send(0, 1, 9'h144);
      begin
        @(negedge clk);
        chk("t5_first_in0_ready", 32'(b2.in0_ready), 32'd1);
        chk("t5_first_in1_ready", 32'(b2.in1_ready), 32'd0);
      end
    join
    repeat (3) tick();
    chk("t5_count", 32'(olen[0]), 32'd2);
    chk("t5_flit0", 32'(olog[0][0]), 32'h033);
    chk("t5_flit1", 32'(olog[0][1]), 32'h344);

`ifdef NOC_MERGE_STATS_EN
    // Accept counters and saturation.
    pulse_reset();
    for (int i = 0; i < 5; i++) send(0, 0, 9'(i + 1));
    for (int i = 0; i < 3; i++) send(0, 1, 9'(i + 9));
    tick();
    chk("st_cnt0", 32'(s2c0), 32'd5);
    chk("st_cnt1", 32'(s2c1), 32'd3);
    set_in(0, 0, 9'h0F0, 1'b1);
    repeat (65529) tick();
    chk("st_cnt0_fffe", 32'(s2c0), 32'hFFFE);
    repeat (10) tick();
    chk("st_cnt0_sat", 32'(s2c0), 32'hFFFF);
    chk("st_cnt1_hold", 32'(s2c1), 32'd3);
    set_in(0, 0, 9'h0F0, 1'b0);
    repeat (3) tick();
`endif

    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
